// File: rtl/fpm_rr_sequencer.sv
// Round-robin sequencer sharing one FP multiplier between two requesters.
// Optional watchdog on every multiplier wait state: define FPM_SEQ_TIMEOUT_EN.
module fpm_rr_sequencer #(
    parameter int WIDTH          = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             req1_ready,
    output logic             rsp0_valid,
    output logic             rsp1_valid,
    input  logic             rsp0_ready,
    input  logic             rsp1_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_err,
    output logic             grant_id,
    output logic             busy,
    output logic [WIDTH-1:0] mul_a,
    output logic [WIDTH-1:0] mul_b,
    output logic             mul_in_ready,
    input  logic             mul_in_accept,
    output logic             mul_start_fp,
    input  logic             mul_done_fp,
    output logic             mul_start_mul,
    input  logic             mul_done_mul,
    input  logic             mul_result_ready,
    output logic             mul_result_accepted,
    input  logic [WIDTH-1:0] mul_result,
    output logic [2:0]       fsm_state
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are
    // both high; valid and payload stay stable until that edge.

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_LOAD     = 3'd1,
        S_FP       = 3'd2,
        S_MUL      = 3'd3,
        S_WAIT_RES = 3'd4,
        S_RESP     = 3'd5
    } state_t;

    state_t state, state_next;
    logic   entry;
    logic   rr_ptr;
    logic   take, take_id;
    logic   load_result;
    logic   rsp_take;

    always_comb begin
        take    = 1'b0;
        take_id = rr_ptr;
        if (req0_valid && req1_valid) begin
            take    = 1'b1;
            take_id = rr_ptr;
        end else if (req0_valid) begin
            take    = 1'b1;
            take_id = 1'b0;
        end else if (req1_valid) begin
            take    = 1'b1;
            take_id = 1'b1;
        end
    end

    assign rsp_take = (state == S_RESP) && (grant_id ? rsp1_ready : rsp0_ready);

`ifdef FPM_SEQ_TIMEOUT_EN
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);
    logic [7:0] tmo_cnt;
    logic       in_wait;
    logic       tmo_fire;
    assign in_wait = (state == S_LOAD) || (state == S_FP) ||
                     (state == S_MUL)  || (state == S_WAIT_RES);
`else
    logic unused_tmo;
    assign unused_tmo = ^8'(TIMEOUT_CYCLES);
    assign rsp_err    = 1'b0;
`endif

    always_comb begin
        state_next  = state;
        load_result = 1'b0;
        case (state)
            S_IDLE:     if (take) state_next = S_LOAD;
            S_LOAD:     if (mul_in_accept) state_next = S_FP;
            // done arriving alongside the start pulse belongs to no request yet
            S_FP:       if (!entry && mul_done_fp) state_next = S_MUL;
            S_MUL:      if (!entry && mul_done_mul) state_next = S_WAIT_RES;
            S_WAIT_RES: if (mul_result_ready) begin
                            state_next  = S_RESP;
                            load_result = 1'b1;
                        end
            S_RESP:     if (rsp_take) state_next = S_IDLE;
            default:    state_next = S_IDLE;
        endcase
`ifdef FPM_SEQ_TIMEOUT_EN
        tmo_fire = 1'b0;
        if (in_wait && (tmo_cnt == TMO_LAST) && (state_next == state)) begin
            tmo_fire   = 1'b1;
            state_next = S_RESP;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_IDLE;
            entry      <= 1'b0;
            rr_ptr     <= 1'b0;
            grant_id   <= 1'b0;
            req0_ready <= 1'b0;
            req1_ready <= 1'b0;
            mul_a      <= '0;
            mul_b      <= '0;
            rsp_data   <= '0;
`ifdef FPM_SEQ_TIMEOUT_EN
            rsp_err    <= 1'b0;
            tmo_cnt    <= 8'd0;
`endif
        end else begin
            state      <= state_next;
            entry      <= (state_next != state);
            req0_ready <= 1'b0;
            req1_ready <= 1'b0;
            if (state == S_IDLE && take) begin
                grant_id   <= take_id;
                req0_ready <= ~take_id;
                req1_ready <= take_id;
                mul_a      <= take_id ? req1_a : req0_a;
                mul_b      <= take_id ? req1_b : req0_b;
            end
            if (load_result) rsp_data <= mul_result;
            if (rsp_take) rr_ptr <= ~grant_id;
`ifdef FPM_SEQ_TIMEOUT_EN
            if (state_next != state) tmo_cnt <= 8'd0;
            else if (in_wait) tmo_cnt <= tmo_cnt + 8'd1;
            if (tmo_fire) begin
                rsp_data <= WIDTH'(32'h7FC00000);
                rsp_err  <= 1'b1;
            end
            if (rsp_take) rsp_err <= 1'b0;
`endif
        end
    end

    assign mul_in_ready        = (state == S_LOAD);
    assign mul_start_fp        = (state == S_FP) && entry;
    assign mul_start_mul       = (state == S_MUL) && entry;
    assign mul_result_accepted = load_result;
    assign rsp0_valid          = (state == S_RESP) && !grant_id;
    assign rsp1_valid          = (state == S_RESP) && grant_id;
    assign busy                = (state != S_IDLE);
    assign fsm_state           = state;

endmodule

// File: tb/tb_fpm_rr_sequencer.sv
// Directed scoreboard bench for fpm_rr_sequencer with a behavioural multiplier.
`timescale 1ns/1ps
module tb_fpm_rr_sequencer;
    localparam int W = 32;
    localparam int ACK = 2;
    localparam logic [2:0] S_FP = 3'd2, S_MUL = 3'd3;

    logic clk, rst;
    logic req0_valid, req0_ready, req1_valid, req1_ready;
    logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
    logic rsp0_valid, rsp1_valid, rsp0_ready, rsp1_ready;
    logic [W-1:0] rsp_data;
    logic rsp_err, grant_id, busy;
    logic [W-1:0] mul_a, mul_b, mul_result;
    logic mul_in_ready, mul_in_accept, mul_start_fp, mul_done_fp;
    logic mul_start_mul, mul_done_mul, mul_result_ready, mul_result_accepted;
    logic [2:0] fsm_state;

    fpm_rr_sequencer #(.WIDTH(W), .TIMEOUT_CYCLES(20)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(req1_ready),
        .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid),
        .rsp0_ready(rsp0_ready), .rsp1_ready(rsp1_ready),
        .rsp_data(rsp_data), .rsp_err(rsp_err), .grant_id(grant_id), .busy(busy),
        .mul_a(mul_a), .mul_b(mul_b), .mul_in_ready(mul_in_ready), .mul_in_accept(mul_in_accept),
        .mul_start_fp(mul_start_fp), .mul_done_fp(mul_done_fp),
        .mul_start_mul(mul_start_mul), .mul_done_mul(mul_done_mul),
        .mul_result_ready(mul_result_ready), .mul_result_accepted(mul_result_accepted),
        .mul_result(mul_result), .fsm_state(fsm_state)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_acc = 0;
    logic [W+1:0] exp_q[$];   // {id, err, data}
    bit early_fp = 0;
    bit mul_en = 1;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s actual=timeout required=event", name);
    endtask

    // Hand-computed IEEE-754 products for the operand pairs the bench uses.
    function automatic logic [W-1:0] prod(input logic [W-1:0] a, input logic [W-1:0] b);
        case ({a, b})
            {32'hC0100000, 32'h40900000}: prod = 32'hC1220000;
            {32'h3F800000, 32'h40000000}: prod = 32'h40000000;
            {32'h40400000, 32'h40400000}: prod = 32'h41100000;
            {32'h40A00000, 32'h3F000000}: prod = 32'h40200000;
            {32'hBF800000, 32'h40E00000}: prod = 32'hC0E00000;
            {32'h41200000, 32'h41200000}: prod = 32'h42C80000;
            default:                      prod = 32'hDEADBEEF;
        endcase
    endfunction

    // Multiplier model: every step is acknowledged ACK cycles after it starts.
    int m_phase = 0;
    int m_cnt = 0;
    always @(negedge clk) begin
        mul_in_accept = 1'b0;
        mul_done_fp = 1'b0;
        mul_done_mul = 1'b0;
        mul_result_ready = 1'b0;
        if (!rst || !busy) begin
            m_phase = 0;
            m_cnt = 0;
        end else begin
            case (m_phase)
                0: if (mul_in_ready) begin
                       if (m_cnt == ACK) begin mul_in_accept = 1'b1; m_phase = 1; m_cnt = 0; end
                       else m_cnt++;
                   end
                1: if (mul_start_fp) begin
                       m_cnt = 1;
                       if (early_fp) mul_done_fp = 1'b1;
                   end else if (m_cnt > 0) begin
                       if (m_cnt == ACK) begin mul_done_fp = 1'b1; m_phase = 2; m_cnt = 0; end
                       else m_cnt++;
                   end
                2: if (mul_start_mul) m_cnt = 1;
                   else if (m_cnt > 0) begin
                       if (m_cnt == ACK) begin
                           if (mul_en) begin mul_done_mul = 1'b1; m_phase = 3; m_cnt = 0; end
                       end else m_cnt++;
                   end
                3: if (m_cnt == ACK) begin
                       mul_result_ready = 1'b1;
                       mul_result = prod(mul_a, mul_b);
                       m_phase = 4;
                   end else m_cnt++;
                default: ;
            endcase
        end
    end

    // Monitor: pulse widths, response exclusivity, scoreboard pops.
    logic prev_r0 = 0, prev_r1 = 0, prev_sfp = 0, prev_smul = 0;
    always @(negedge clk) begin
        logic [W+1:0] e;
        cyc++;
        if (rst) begin
            if (req0_ready) begin
                chk("req0_ready_width", W'(prev_r0), 0);
                chk("req0_ready_with_valid", W'(req0_valid), 1);
                last_acc = cyc;
            end
            if (req1_ready) begin
                chk("req1_ready_width", W'(prev_r1), 0);
                chk("req1_ready_with_valid", W'(req1_valid), 1);
                last_acc = cyc;
            end
            if (mul_start_fp) chk("start_fp_width", W'(prev_sfp), 0);
            if (mul_start_mul) chk("start_mul_width", W'(prev_smul), 0);
            if (rsp0_valid || rsp1_valid) chk("rsp_valid_exclusive", W'(rsp0_valid & rsp1_valid), 0);
            if ((rsp0_valid && rsp0_ready) || (rsp1_valid && rsp1_ready)) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_rsp actual=%h required=none", rsp_data);
                end else begin
                    e = exp_q.pop_front();
                    chk("rsp_id", W'(rsp1_valid), W'(e[W+1]));
                    chk("rsp_grant_id", W'(grant_id), W'(e[W+1]));
                    chk("rsp_err", W'(rsp_err), W'(e[W]));
                    chk("rsp_data", rsp_data, e[W-1:0]);
                    chk("latency_min6", W'(cyc - last_acc >= 6), 1);
                end
            end
        end
        prev_r0 = req0_ready;
        prev_r1 = req1_ready;
        prev_sfp = mul_start_fp;
        prev_smul = mul_start_mul;
    end

    task automatic send(input bit id, input logic [W-1:0] a, input logic [W-1:0] b);
        bit got = 0;
        @(posedge clk); #1;
        if (id) begin req1_valid = 1'b1; req1_a = a; req1_b = b; end
        else begin req0_valid = 1'b1; req0_a = a; req0_b = b; end
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (id ? req1_ready : req0_ready) begin got = 1; break; end
        end
        if (!got) fail_now(id ? "req1_ready_wait" : "req0_ready_wait");
        @(posedge clk); #1;
        if (id) req1_valid = 1'b0;
        else req0_valid = 1'b0;
    endtask

    task automatic push(input bit id, input bit err, input logic [W-1:0] d);
        exp_q.push_back({id, err, d});
    endtask

    task automatic drain();
        bit ok = 0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !busy) begin ok = 1; break; end
        end
        if (!ok) fail_now("drain");
    endtask

    task automatic wait_state(input logic [2:0] s);
        bit ok = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (fsm_state == s) begin ok = 1; break; end
        end
        if (!ok) fail_now("wait_state");
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_req0_ready"}, W'(req0_ready), 0);
        chk({tag, "_req1_ready"}, W'(req1_ready), 0);
        chk({tag, "_rsp0_valid"}, W'(rsp0_valid), 0);
        chk({tag, "_rsp1_valid"}, W'(rsp1_valid), 0);
        chk({tag, "_rsp_data"}, rsp_data, 0);
        chk({tag, "_rsp_err"}, W'(rsp_err), 0);
        chk({tag, "_busy"}, W'(busy), 0);
        chk({tag, "_grant_id"}, W'(grant_id), 0);
        chk({tag, "_in_ready"}, W'(mul_in_ready), 0);
        chk({tag, "_start_fp"}, W'(mul_start_fp), 0);
        chk({tag, "_start_mul"}, W'(mul_start_mul), 0);
        chk({tag, "_result_accepted"}, W'(mul_result_accepted), 0);
    endtask

    initial begin
        #500000;
        fail_now("watchdog");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        bit ok;
        int n;
        rst = 1'b0;
        req0_valid = 0; req1_valid = 0;
        req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        mul_result = '0;
        #12;
        chk_all_zero("reset");
        @(posedge clk); #1 rst = 1'b1;

        // single request
        push(0, 0, 32'hC1220000);
        send(0, 32'hC0100000, 32'h40900000);
        drain();

        // fresh pointer, simultaneous requests: requester 0 first
        @(posedge clk); #1 rst = 1'b0;
        @(posedge clk); #1 rst = 1'b1;
        push(0, 0, 32'h40000000);
        push(1, 0, 32'h41100000);
        fork
            send(0, 32'h3F800000, 32'h40000000);
            send(1, 32'h40400000, 32'h40400000);
        join
        drain();

        // serve requester 0 alone, then a simultaneous pair favours requester 1
        push(0, 0, 32'h40200000);
        send(0, 32'h40A00000, 32'h3F000000);
        drain();
        push(1, 0, 32'h42C80000);
        push(0, 0, 32'hC0E00000);
        fork
            send(0, 32'hBF800000, 32'h40E00000);
            send(1, 32'h41200000, 32'h41200000);
        join
        drain();

        // done during the start_fp pulse must not advance the FSM
        early_fp = 1;
        push(1, 0, 32'h40000000);
        fork
            send(1, 32'h3F800000, 32'h40000000);
            begin
                ok = 0;
                for (int i = 0; i < 100; i++) begin
                    @(negedge clk);
                    if (mul_start_fp) begin ok = 1; break; end
                end
                if (!ok) fail_now("start_fp_wait");
                @(negedge clk);
                chk("early_done_ignored", W'(fsm_state), W'(S_FP));
            end
        join
        drain();
        early_fp = 0;

        // response backpressure holds the block in RESP
        rsp0_ready = 1'b0;
        push(0, 0, 32'hC1220000);
        push(1, 0, 32'h40200000);
        fork
            send(0, 32'hC0100000, 32'h40900000);
            send(1, 32'h40A00000, 32'h3F000000);
            begin
                ok = 0;
                for (int i = 0; i < 100; i++) begin
                    @(negedge clk);
                    if (rsp0_valid) begin ok = 1; break; end
                end
                if (!ok) fail_now("rsp0_valid_wait");
                for (int i = 0; i < 10; i++) begin
                    chk("bp_rsp0_valid", W'(rsp0_valid), 1);
                    chk("bp_rsp_data", rsp_data, 32'hC1220000);
                    chk("bp_no_grant", W'(req1_ready), 0);
                    @(negedge clk);
                end
                @(posedge clk); #1 rsp0_ready = 1'b1;
                @(posedge clk);
                @(posedge clk);
                @(negedge clk);
                chk("bp_next_grant_ready", W'(req1_ready), 1);
                chk("bp_next_grant_id", W'(grant_id), 1);
            end
        join
        drain();

        // reset in the middle of MUL aborts without a response
        send(1, 32'h40400000, 32'h40400000);
        wait_state(S_MUL);
        #2 rst = 1'b0;
        #1 chk_all_zero("abort");
        @(posedge clk);
        @(posedge clk); #1 rst = 1'b1;
        push(1, 0, 32'h42C80000);
        send(1, 32'h41200000, 32'h41200000);
        drain();

`ifdef FPM_SEQ_TIMEOUT_EN
        // missing done_mul: watchdog fires after 20 cycles in MUL
        mul_en = 0;
        push(0, 1, 32'h7FC00000);
        send(0, 32'h3F800000, 32'h40000000);
        wait_state(S_MUL);
        n = 0;
        while (fsm_state == S_MUL && n < 100) begin
            n++;
            @(negedge clk);
        end
        chk("timeout_mul_cycles", W'(n), 20);
        drain();
        mul_en = 1;
        push(0, 0, 32'h40000000);
        send(0, 32'h3F800000, 32'h40000000);
        drain();
`else
        n = 0;
`endif

        chk("queue_empty", W'(exp_q.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
